// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Types and constants shared by the instruction fetch front end.
//               fetch_pkt_t pairs an instruction word with the PC it came from.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int FETCH_ADDR_WIDTH = 32;
    localparam int INSTR_BYTES      = 4;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [31:0]                 instr;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bus bundle for the fetch stage: the instruction-memory request
//               and response port, plus the valid/ready fetch-packet stream.
//               master = fetch stage, slave = memory/decode side.
//   imem_req / imem_addr  : read request, word-aligned byte address
//   imem_rdata            : word returned the cycle after the request
//   valid_out / data_out  : fetch packet stream, ready_out is the back-pressure
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  valid_out;
    logic                  ready_out;
    fetch_pkt_t            data_out;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output valid_out,
        output data_out,
        input  ready_out
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  valid_out,
        input  data_out,
        output ready_out
    );

endinterface
`default_nettype wire

// File: rtl/fetch_resp_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_resp_buf
// Description : Two-entry ordered response buffer (output slot + overflow
//               hold slot) driving a registered valid/ready stream.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : discard everything buffered and the incoming response
//   in_valid_i   : a response is presented this cycle (in_pkt_i)
//   ready_i      : downstream accepts pkt_o
//   valid_o/pkt_o: registered head of the buffer
//   count_o      : number of entries currently held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_resp_buf
    import riscv_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       flush_i,
    input  wire logic       in_valid_i,
    input  wire fetch_pkt_t in_pkt_i,
    input  wire logic       ready_i,
    output logic            valid_o,
    output fetch_pkt_t      pkt_o,
    output logic [1:0]      count_o
);

    logic       out_valid_q, out_valid_d;
    logic       hold_valid_q, hold_valid_d;
    fetch_pkt_t out_q, out_d;
    fetch_pkt_t hold_q, hold_d;
    logic       w_fire;

    assign w_fire  = out_valid_q && ready_i;
    assign valid_o = out_valid_q;
    assign pkt_o   = out_q;
    assign count_o = {1'b0, out_valid_q} + {1'b0, hold_valid_q};

    always_comb begin
        out_valid_d  = out_valid_q;
        hold_valid_d = hold_valid_q;
        out_d        = out_q;
        hold_d       = hold_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
        end else if (in_valid_i) begin
            if ((!out_valid_q || w_fire) && !hold_valid_q) begin
                out_valid_d = 1'b1;
                out_d       = in_pkt_i;
            end else if (w_fire && hold_valid_q) begin
                // Hold slides forward, new response takes its place.
                out_d  = hold_q;
                hold_d = in_pkt_i;
            end else begin
                // Head is stalled; the issue credit guarantees hold is free.
                hold_valid_d = 1'b1;
                hold_d       = in_pkt_i;
            end
        end else if (w_fire) begin
            if (hold_valid_q) begin
                out_d        = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            hold_valid_q <= hold_valid_d;
        end
        out_q  <= out_d;
        hold_q <= hold_d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the PC, issues one word read
//               per cycle to a synchronous-read memory, and streams {pc,instr}
//               packets downstream. Issue is throttled by a credit count so at
//               most two packets are ever buffered; redirect flushes all
//               wrong-path work.
//   clk, reset      : clock, synchronous active-high reset
//   bus (master)    : imem_req/imem_addr/imem_rdata, valid_out/ready_out/data_out
//   redirect_valid  : flush and restart fetch at redirect_pc (word aligned)
//   perf_fetched    : accepted-packet count   (only with FETCH_PERF_CNT_EN)
//   perf_stall      : stalled-packet cycles    (only with FETCH_PERF_CNT_EN)
// Configuration: define FETCH_PERF_CNT_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    fetch_stage_if.master              bus,
    input  wire logic                  redirect_valid,
    input  wire logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_stall
`endif
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  pending_q, pending_d;
    logic                  w_buf_valid;
    logic [1:0]            w_buf_count;
    logic                  w_fire;
    logic [2:0]            w_occ;
    logic                  w_issue;
    fetch_pkt_t            w_resp_pkt;

    // Valid is forced low while reset is asserted so nothing leaks out of a
    // buffer that is about to be cleared.
    assign bus.valid_out = w_buf_valid && !reset;
    assign w_fire        = bus.valid_out && bus.ready_out;

    // Packets that will still be held after this cycle, including the one in
    // flight; fire implies count >= 1 so this never underflows.
    assign w_occ   = 3'(w_buf_count) + 3'(pending_q) - 3'(w_fire);
    assign w_issue = !reset && !redirect_valid && (w_occ < 3'd2);

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = pc_q;

    assign w_resp_pkt.pc    = req_pc_q;
    assign w_resp_pkt.instr = bus.imem_rdata;

    always_comb begin
        pc_d      = pc_q;
        pending_d = 1'b0;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (w_issue) begin
            pc_d      = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC[ADDR_WIDTH-1:0];
            pending_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
        if (w_issue) begin
            req_pc_q <= pc_q;
        end
    end

    fetch_resp_buf u_resp_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .in_valid_i (pending_q && !redirect_valid),
        .in_pkt_i   (w_resp_pkt),
        .ready_i    (bus.ready_out),
        .valid_o    (w_buf_valid),
        .pkt_o      (bus.data_out),
        .count_o    (w_buf_count)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (w_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.valid_out && !bus.ready_out) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

- Front-end instruction fetch stage.
- Holds the PC and issues one word-aligned request per cycle to a synchronous-read instruction memory.
- Packs each returned word with its PC into a fetch packet and presents it on a valid/ready stream to the decode-side skid buffer.
- Absorbs downstream stalls without losing in-flight responses, and discards wrong-path work on a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.
- ADDR_WIDTH, 32, PC and memory address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  ADDR_WIDTH  byte address of the request, always word aligned.
- imem_rdata  input  32  instruction word, valid the cycle after its request.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] are ignored and forced to 0.
- valid_out  output  1  fetch packet valid.
- ready_out  input  1  downstream accepts the packet.
- data_out  output  fetch_pkt_t  {pc, instr}.

## Operation
- State:
  - pc_reg
  - pending: a response arrives this cycle
  - out_valid and out_reg
  - hold_valid and hold_reg: one-entry overflow
- Definitions:
  - fire_out = valid_out && ready_out.
  - occ = out_valid + hold_valid + pending − fire_out (0..3).
- Issue rule:
  - imem_req = !reset && !redirect_valid && occ < 2.
  - imem_addr = pc_reg.
  - On issue, pc_reg <= pc_reg + 4 (modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0) and pending <= 1. Otherwise pending <= 0.
- Response routing, when pending is set and there is no redirect:
  - If the output slot is free or draining (!out_valid || fire_out) and hold is empty: write to out_reg.
  - Otherwise: write to hold_reg.
- Hold refill: when fire_out and hold_valid, hold_reg moves to out_reg and the same cycle's response goes to hold_reg. Packet order is always preserved.
- valid_out = out_valid; data_out = out_reg. Both are registered, with no combinational path from ready_out.
- Redirect takes priority over everything in the same cycle:
  - pc_reg <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - out_valid, hold_valid and pending are cleared.
  - Any response arriving that cycle is dropped, and no request is issued that cycle.
  - An unaccepted packet is discarded. A packet with fire_out in the redirect cycle counts as consumed.
- Reset:
  - pc_reg = RESET_PC; pending, out_valid and hold_valid = 0.
  - imem_req = 0 and valid_out = 0 while reset is high.
  - Reset mid-operation discards all in-flight and buffered packets.

## Timing
- Request in cycle n gives data in cycle n+1, captured at the end of n+1, so valid_out is high in cycle n+2.
- Throughput is one packet per cycle while ready_out is held high: steady state occ = 1.
- Stall: at most one extra response lands in hold. Issue stops while occ ≥ 2.
- After ready_out returns, the held packets drain back-to-back with no bubble, and issue resumes the same cycle occ < 2.
- First packet after reset deasserts or after a redirect: valid_out in the 2nd cycle following.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs.
  - perf_fetched [31:0] counts fire_out cycles.
  - perf_stall [31:0] counts valid_out && !ready_out cycles.
  - Both reset to 0, wrap at 2^32, and are unaffected by redirect.
- Macro undefined: the ports and counters do not exist, and there is no behavioural difference otherwise.

## Structure
- Shared package riscv_pkg holds:
  - fetch_pkt_t {logic [ADDR_WIDTH-1:0] pc; logic [31:0] instr;}
  - the INSTR_BYTES = 4 constant.
- Sub-module fetch_resp_buf: the out/hold two-entry ordered buffer with valid/ready output and a flush input.
- The PC, issue-credit logic and redirect live in fetch_stage.

## Test plan
- Reset with RESET_PC = 0x100, ready_out = 1, imem model returning addr^0xA5A5_0000 → packets {0x100,…}, {0x104,…}, {0x108,…} on consecutive cycles; first valid_out 2 cycles after reset falls.
- Steady stream, then ready_out = 0 for 5 cycles → valid_out holds the same packet, imem_req low after at most 1 extra request, and no packet is lost or duplicated after release.
- Release the stall → held packets emerge back-to-back in PC order, and imem_req reasserts the same cycle occ < 2.
- redirect_valid with redirect_pc = 0x203 while a packet is held and a request is in flight → both dropped, next request addr 0x200, next packet pc 0x200.
- pc_reg = 0xFFFF_FFF8, free run → packets pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted during a stall with hold full → valid_out = 0 next cycle, and fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
